// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module  : cpu_pkg
//  Purpose : Shared fetch-FSM state encoding, halt opcode and field positions.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_LATCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } fetch_state_t;

  localparam logic [5:0]  c_HALT_OP  = 6'h3F;
  localparam int          c_OPC_MSB  = 31;
  localparam int          c_OPC_LSB  = 26;
  localparam logic [31:0] c_IR_RESET = 32'hFC00_0000;

  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[c_OPC_MSB:c_OPC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
//  Module  : instr_fetch_if
//  Purpose : Instruction-memory bus plus microcode-sequencer handshake.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [5:0]  opcode;
  logic        sos;
  logic        eos;
  logic        pc_load;
  logic [31:0] pc_target;

  modport master (
    output imem_addr, imem_rd, opcode, sos,
    input  imem_data, imem_ready, eos, pc_load, pc_target
  );

  modport slave (
    input  imem_addr, imem_rd, opcode, sos,
    output imem_data, imem_ready, eos, pc_load, pc_target
  );
endinterface

`default_nettype wire

// File: rtl/eos_watchdog.sv
// ============================================================================
//  Module  : eos_watchdog
//  Purpose : Counts EXEC cycles; expired flags the cycle that hits TIMEOUT.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eos_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  output logic expired
);

  localparam int c_CW = $clog2(TIMEOUT + 1);

  logic [c_CW-1:0] r_count;

  // r_count holds the number of completed EXEC cycles, so the current one is r_count+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (start && (r_count != c_CW'(TIMEOUT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = start && (r_count == c_CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
//  Module  : instr_fetch
//  Purpose : Fetch/issue sequencer handing opcodes to the microcode engine.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP     = c_HALT_OP,
  parameter int          EOS_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus,
  output logic [31:0]  ir,
  output logic [31:0]  pc,
  output logic [31:0]  retired,
  output logic         halted,
  output logic         fault
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [5:0]   r_opcode;
  logic         r_sos;
  logic         r_imem_rd;
  logic [31:0]  r_retired;
  logic         r_halted;
  logic         r_fault;
  logic         r_branch;
  logic [31:0]  r_target;
  logic         r_exec_first;
  logic         w_expired;

  eos_watchdog #(
    .TIMEOUT (EOS_TIMEOUT)
  ) u_eos_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == ST_ISSUE),
    .start   (r_state == ST_EXEC),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= c_IR_RESET;
      r_opcode     <= HALT_OP;
      r_sos        <= 1'b0;
      r_imem_rd    <= 1'b1;
      r_retired    <= 32'd0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_branch     <= 1'b0;
      r_target     <= 32'd0;
      r_exec_first <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            r_ir      <= bus.imem_data;
            r_opcode  <= get_opcode(bus.imem_data);
            r_imem_rd <= 1'b0;
            r_state   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (get_opcode(r_ir) == HALT_OP) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_sos   <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_sos        <= 1'b0;
          r_exec_first <= 1'b1;
          r_state      <= ST_EXEC;
        end
        ST_EXEC: begin
          r_exec_first <= 1'b0;
          if (bus.pc_load) begin
            r_branch <= 1'b1;
            r_target <= bus.pc_target;
          end
          // First EXEC cycle may still see eos left over from the previous segment
          if (!r_exec_first && bus.eos) begin
            r_state <= ST_UPDATE;
          end else if (w_expired) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end
        end
        ST_UPDATE: begin
          r_pc      <= r_branch ? (r_target & 32'hFFFF_FFFC) : (r_pc + 32'd4);
          r_retired <= r_retired + 32'd1;
          r_branch  <= 1'b0;
          r_imem_rd <= 1'b1;
          r_state   <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_imem_rd <= 1'b0;
          r_sos     <= 1'b0;
          r_halted  <= 1'b1;
          r_state   <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.imem_rd   = r_imem_rd;
  assign bus.opcode    = r_opcode;
  assign bus.sos       = r_sos;
  assign ir            = r_ir;
  assign pc            = r_pc;
  assign retired       = r_retired;
  assign halted        = r_halted;
  assign fault         = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
//  Module  : tb_instr_fetch
//  Purpose : Randomised directed bench for instr_fetch with a transaction model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int          c_TMO      = 64;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC    (c_RESET_PC),
    .HALT_OP     (6'h3F),
    .EOS_TIMEOUT (c_TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ir      (ir),
    .pc      (pc),
    .retired (retired),
    .halted  (halted),
    .fault   (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ready = 1'b0;
    bus.imem_data  = $urandom;
    bus.eos        = 1'b0;
    bus.pc_load    = 1'b0;
    bus.pc_target  = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    check("rst_pc", pc, c_RESET_PC);
    check("rst_ir", ir, 32'hFC00_0000);
    check("rst_opcode", {26'd0, bus.opcode}, 32'h3F);
    check("rst_sos", {31'd0, bus.sos}, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_fault", {31'd0, fault}, 0);
    rst   = 1'b0;
    m_pc  = c_RESET_PC;
    m_ret = 32'd0;
    check("first_rd", {31'd0, bus.imem_rd}, 1);
  endtask

  // Serve one fetch: wait rdy_dly cycles, then present word; ends in LATCH.
  task automatic fetch_word(input int rdy_dly, input logic [31:0] word);
    check("fetch_rd", {31'd0, bus.imem_rd}, 1);
    check("fetch_addr", bus.imem_addr, m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.imem_ready = 1'b0;
      bus.pc_load    = 1'($urandom_range(0, 1));
      bus.pc_target  = $urandom;
      step();
      check("wait_rd", {31'd0, bus.imem_rd}, 1);
      check("wait_addr", bus.imem_addr, m_pc);
    end
    bus.imem_ready = 1'b1;
    bus.imem_data  = word;
    step();
    bus.imem_ready = 1'b0;
    bus.imem_data  = $urandom;
    check("latch_ir", ir, word);
    check("latch_opcode", {26'd0, bus.opcode}, {26'd0, word[31:26]});
    check("latch_sos", {31'd0, bus.sos}, 0);
    check("latch_rd", {31'd0, bus.imem_rd}, 0);
  endtask

  // eos_low = EXEC cycles with eos low before it rises (0: high from ISSUE on).
  task automatic run_instr(input int rdy_dly, input int eos_low, input bit force_br,
                           input logic [31:0] force_tgt, input int br_pct);
    logic [31:0] word;
    logic [31:0] m_tgt;
    bit          m_br;
    bit          timeout;
    bit          done;
    int          k_acc;
    int          j;
    int          sos_hits;
    word = $urandom;
    if (word[31:26] == 6'h3F) word[31:26] = 6'h01;
    fetch_word(rdy_dly, word);
    bus.pc_load   = 1'($urandom_range(0, 1));
    bus.pc_target = $urandom;
    step();
    check("issue_sos", {31'd0, bus.sos}, 1);
    timeout  = (eos_low >= c_TMO);
    k_acc    = (eos_low + 1 < 2) ? 2 : eos_low + 1;
    m_br     = 1'b0;
    m_tgt    = 32'd0;
    j        = 0;
    done     = 1'b0;
    sos_hits = 0;
    while (!done) begin
      bus.eos       = (eos_low == 0) || (j > eos_low);
      bus.pc_load   = ($urandom_range(0, 99) < br_pct);
      bus.pc_target = $urandom;
      if (force_br && j == k_acc) begin
        bus.pc_load   = 1'b1;
        bus.pc_target = force_tgt;
      end
      if (bus.pc_load && j >= 1 && (timeout ? j <= c_TMO : j <= k_acc)) begin
        m_br  = 1'b1;
        m_tgt = bus.pc_target;
      end
      step();
      j++;
      if (bus.sos) sos_hits++;
      if (bus.imem_rd || halted || j > c_TMO + 10) done = 1'b1;
    end
    idle_inputs();
    check("exec_sos_count", sos_hits, 0);
    if (timeout) begin
      check("tmo_len", j, c_TMO + 1);
      check("tmo_fault", {31'd0, fault}, 1);
      check("tmo_halted", {31'd0, halted}, 1);
      check("tmo_rd", {31'd0, bus.imem_rd}, 0);
      check("tmo_retired", retired, m_ret);
    end else begin
      m_pc  = m_br ? (m_tgt & 32'hFFFF_FFFC) : (m_pc + 32'd4);
      m_ret = m_ret + 32'd1;
      check("exec_len", j, k_acc + 2);
      check("retired", retired, m_ret);
      check("next_addr", bus.imem_addr, m_pc);
      check("fault_clear", {31'd0, fault}, 0);
    end
  endtask

  initial begin
    int sos_hits;
    int rd_hits;

    do_reset();

    // straight-line code at 0,4,8
    for (int i = 0; i < 3; i++) run_instr(1, $urandom_range(1, 3), 1'b0, 32'd0, 0);
    check("straight_retired", retired, 3);
    check("straight_pc", pc, 32'd12);

    // single-microinstruction segments
    for (int i = 0; i < 3; i++) run_instr(1, 0, 1'b0, 32'd0, 0);

    // branch in the eos cycle, low address bits dropped
    run_instr(0, 2, 1'b1, 32'h0000_0043, 0);
    check("branch_addr", bus.imem_addr, 32'h0000_0040);

    for (int i = 0; i < 25; i++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 6), 1'b0, 32'd0, 30);
    run_instr(0, c_TMO - 1, 1'b0, 32'd0, 10);

    // reset mid-EXEC takes effect without waiting for a clock edge
    fetch_word(0, 32'h1234_5678);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("amid_pc", pc, c_RESET_PC);
    check("amid_opcode", {26'd0, bus.opcode}, 32'h3F);
    check("amid_retired", retired, 0);
    check("amid_sos", {31'd0, bus.sos}, 0);
    check("amid_rd", {31'd0, bus.imem_rd}, 1);
    do_reset();

    // halt opcode: no sos, read request stays low
    run_instr(1, 1, 1'b0, 32'd0, 0);
    fetch_word(1, 32'hFC00_0000);
    step();
    check("halt_halted", {31'd0, halted}, 1);
    check("halt_sos", {31'd0, bus.sos}, 0);
    sos_hits = 0;
    rd_hits  = 0;
    for (int i = 0; i < 100; i++) begin
      bus.imem_ready = 1'($urandom_range(0, 1));
      bus.eos        = 1'($urandom_range(0, 1));
      bus.pc_load    = 1'($urandom_range(0, 1));
      bus.pc_target  = $urandom;
      step();
      if (bus.sos) sos_hits++;
      if (bus.imem_rd) rd_hits++;
    end
    idle_inputs();
    check("halt_sos_count", sos_hits, 0);
    check("halt_rd_count", rd_hits, 0);
    check("halt_stays", {31'd0, halted}, 1);
    check("halt_pc", pc, m_pc);
    check("halt_retired", retired, m_ret);
    check("halt_no_fault", {31'd0, fault}, 0);

    // eos stuck low
    do_reset();
    run_instr(0, 1, 1'b0, 32'd0, 0);
    run_instr(0, c_TMO + 20, 1'b0, 32'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter HALT_OP, default 6'h3F, is the opcode that stops the sequencer.
REQ-003 Parameter EOS_TIMEOUT, default 64, is the maximum number of EXEC cycles allowed before a fault.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single rising-edge clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port imem_addr, output, 32 bits: instruction memory address, equal to pc.
REQ-008 Port imem_rd, output, 1 bit: instruction read request.
REQ-009 Port imem_data, input, 32 bits: instruction word, valid when imem_ready is 1.
REQ-010 Port imem_ready, input, 1 bit: read-complete strobe.
REQ-011 Port ir, output, 32 bits: latched instruction register.
REQ-012 Port opcode, output, 6 bits: ir[31:26], driven to the microcode sequencer.
REQ-013 Port sos, output, 1 bit: start-of-segment pulse to the microcode sequencer.
REQ-014 Port eos, input, 1 bit: end-of-segment level from the microcode sequencer.
REQ-015 Port pc_load, input, 1 bit: branch or jump taken request.
REQ-016 Port pc_target, input, 32 bits: branch or jump destination.
REQ-017 Port pc, output, 32 bits: current program counter.
REQ-018 Port retired, output, 32 bits: retired-instruction count.
REQ-019 Port halted, output, 1 bit: set in the HALT state.
REQ-020 Port fault, output, 1 bit: EOS-timeout flag.

Function
REQ-021 The FSM SHALL have the states FETCH, LATCH, ISSUE, EXEC, UPDATE and HALT.
REQ-022 FETCH: imem_rd SHALL be 1 and imem_addr SHALL equal pc; on imem_ready=1, ir SHALL take imem_data and the FSM SHALL go to LATCH.
REQ-023 FETCH SHALL wait indefinitely while imem_ready is 0, with imem_rd held at 1.
REQ-024 LATCH: if ir[31:26] equals HALT_OP, the FSM SHALL go to HALT without pulsing sos; otherwise it SHALL go to ISSUE.
REQ-025 ISSUE: sos SHALL be 1 for exactly one cycle; sos SHALL be 0 in every other state.
REQ-026 EXEC SHALL ignore eos in its first cycle, because the sequencer may still hold eos from the previous segment.
REQ-027 From the second EXEC cycle onward, eos=1 SHALL move the FSM to UPDATE.
REQ-028 A single-microinstruction segment (eos high continuously) SHALL therefore spend exactly 2 cycles in EXEC.
REQ-029 pc_load SHALL be captured into a sticky flag in any EXEC cycle, including the cycle in which eos is accepted, together with pc_target.
REQ-030 If pc_load is asserted more than once in one instruction, the last pc_target SHALL win.
REQ-031 UPDATE: pc SHALL become {target[31:2],2'b00} if the sticky flag is set, else pc+4 with 32-bit wrap.
REQ-032 UPDATE SHALL increment retired (wrapping), clear the sticky flag and go to FETCH.
REQ-033 The EXEC cycle counter SHALL reset on entry to EXEC.
REQ-034 If the EXEC cycle counter reaches EOS_TIMEOUT without eos being accepted, fault SHALL be set and the FSM SHALL go to HALT.
REQ-035 In HALT, halted SHALL be 1 and imem_rd and sos SHALL be 0; HALT SHALL be left only by reset.
REQ-036 Latency from imem_ready to sos SHALL be 2 cycles (LATCH, then ISSUE).
REQ-037 Latency from eos acceptance to the next imem_rd SHALL be 2 cycles (UPDATE, then FETCH).
REQ-038 pc_load outside EXEC SHALL be ignored.

Reset
REQ-039 On rst=1, asynchronously: state=FETCH, pc=RESET_PC, ir=32'hFC00_0000, opcode=HALT_OP, sos=0, retired=0, halted=0, fault=0, sticky flag=0.
REQ-040 The reset value of opcode SHALL be HALT_OP, so the sequencer stays frozen until the first fetch.
REQ-041 Reset asserted mid-operation SHALL abort any fetch or segment, with no sos glitch.
REQ-042 imem_rd SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-043 The state enum, HALT_OP and the instruction field positions (opcode 31:26) SHALL live in the shared package cpu_pkg.
REQ-044 The EOS timeout counter SHALL be a sub-module named eos_watchdog (start, clear, expired).
REQ-045 The block SHALL have no other sub-modules.

Verification
REQ-046 Scenario, reset then straight-line code: RESET_PC=0, three non-halt words, imem_ready after 1 cycle -> imem_addr 0,4,8; one sos per word; retired=3.
REQ-047 Scenario, single-cycle segment: eos held at 1 throughout -> exactly 2 EXEC cycles per instruction; no double sos.
REQ-048 Scenario, branch: pc_load=1, pc_target=32'h0000_0043 in the eos cycle -> next imem_addr = 32'h0000_0040.
REQ-049 Scenario, halt: fetch of 32'hFC00_0000 -> halted=1, no sos, imem_rd=0 held for 100 cycles.
REQ-050 Scenario, timeout: eos stuck at 0 -> fault=1 and halted=1 once EOS_TIMEOUT (64) EXEC cycles elapse without eos.
REQ-051 Scenario, reset mid-EXEC: rst asserted -> pc=RESET_PC, opcode=6'h3F, retired=0 immediately (asynchronously).
